// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the iterative multiply/divide unit.
//   op_e    : operation encoding (MUL, MULHU, DIVU, REMU)
//   state_e : control FSM states
//   DefaultWidth / DefaultRegAddrW : default operand and register-index widths
package muldiv_pkg;

    localparam int unsigned DefaultWidth    = 32;
    localparam int unsigned DefaultRegAddrW = 5;

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulhu = 2'b01,
        OpDivu  = 2'b10,
        OpRemu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the register bank and muldiv_unit.
//   master : bank side, drives start/op/operandA/operandB/destIn
//   slave  : unit side, drives ready/busy/done/writeFlag/result/destOut/illegal
interface muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned REG_ADDR_W = DefaultRegAddrW
) ();

    logic                  start;
    op_e                   op;
    logic [WIDTH-1:0]      operandA;
    logic [WIDTH-1:0]      operandB;
    logic [REG_ADDR_W-1:0] destIn;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic                  writeFlag;
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] destOut;
    logic                  illegal;

    modport master (
        output start, op, operandA, operandB, destIn,
        input  ready, busy, done, writeFlag, result, destOut, illegal
    );

    modport slave (
        input  start, op, operandA, operandB, destIn,
        output ready, busy, done, writeFlag, result, destOut, illegal
    );

endinterface

// File: rtl/muldiv_divider.sv
// muldiv_divider: restoring unsigned divider step registers, one quotient bit per step.
// Instantiated by muldiv_unit only when MULDIV_DIV_EN is defined.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : capture dividend_i/divisor_i and clear the remainder
//   step_i         : perform one restoring step
//   quot_next_o    : quotient after the current step (valid while step_i=1)
//   rem_next_o     : remainder after the current step (valid while step_i=1)
// Divide by zero falls out naturally: every trial subtract succeeds, giving an
// all-ones quotient and a remainder equal to the dividend.
module muldiv_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_next_o,
    output logic [WIDTH-1:0] rem_next_o
);

    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // rem_q stays below the divisor, so shifted < 2^(WIDTH+1) and diff's MSB is the borrow.
    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        diff    = shifted - {2'b00, dvsr_q};
        borrow  = diff[WIDTH+1];
        rem_d   = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        quot_d  = {quot_q[WIDTH-2:0], ~borrow};
    end

    assign quot_next_o = quot_d;
    assign rem_next_o  = rem_d[WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
        end else if (load_i) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            dvsr_q <= divisor_i;
        end else if (step_i) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL/MULHU/DIVU/REMU unit, fixed WIDTH+1 cycle latency.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : start/op/operandA/operandB/destIn in; ready/busy/done/writeFlag/
//                  result/destOut/illegal out
// Build option MULDIV_DIV_EN: when defined, the divider is compiled in. When undefined,
// DIVU/REMU complete one cycle after accept with result=0 and illegal=1.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned REG_ADDR_W = DefaultRegAddrW
) (
    input logic          clock,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    op_e                   op_q, op_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic                  illegal_q, illegal_d;

    logic                  accept;
    logic [WIDTH:0]        mul_sum;
    logic [2*WIDTH-1:0]    acc_step;

    assign accept = bus.start && (state_q != StRun);

    // acc = {high partial sum, unconsumed multiplier bits}; each step adds the
    // multiplicand into the high half if the next multiplier bit is set, then shifts right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    muldiv_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk_i       (clock),
        .rst_i       (reset),
        .load_i      (accept),
        .step_i      (state_q == StRun),
        .dividend_i  (bus.operandA),
        .divisor_i   (bus.operandB),
        .quot_next_o (div_quot),
        .rem_next_o  (div_rem)
    );
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dest_d    = dest_q;
        result_d  = result_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    case (op_q)
                        OpMul:   result_d = acc_step[WIDTH-1:0];
                        OpMulhu: result_d = acc_step[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
                        OpDivu:  result_d = div_quot;
                        OpRemu:  result_d = div_rem;
`endif
                        default: result_d = '0;
                    endcase
                end
            end
            StIdle, StDone: begin
                state_d   = StIdle;
                illegal_d = 1'b0;
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = CntW'(WIDTH);
                    op_d    = bus.op;
                    dest_d  = bus.destIn;
                    mcand_d = bus.operandA;
                    acc_d   = {{WIDTH{1'b0}}, bus.operandB};
`ifdef MULDIV_DIV_EN
`else
                    // No divider: complete immediately so the bank still gets a write of 0.
                    if (bus.op[1]) begin
                        state_d   = StDone;
                        cnt_d     = '0;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= OpMul;
            dest_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ready     = (state_q != StRun);
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.writeFlag = (state_q == StDone);
    assign bus.illegal   = (state_q == StDone) && illegal_q;
    assign bus.result    = result_q;
    assign bus.destOut   = dest_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit sitting directly downstream of the register bank. It consumes the two read operands (dataA/dataB) and computes a 32-bit multiply, high-multiply, divide or remainder over several cycles. It then returns the result together with a write strobe and destination index, which feed the bank's dataWrite/writeFlag/regC write port.

## Interface
Parameters:
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1
- REG_ADDR_W, 5, destination register index width

Ports:
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- op  in  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU (quotient), 11 REMU (remainder)
- operandA  in  WIDTH  multiplicand/dividend, from dataA
- operandB  in  WIDTH  multiplier/divisor, from dataB
- destIn  in  REG_ADDR_W  destination register, captured on accept
- ready  out  1  unit can accept start this cycle
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse, result valid
- writeFlag  out  1  equals done; drives bank write enable
- result  out  WIDTH  result; held until the next accept
- destOut  out  REG_ADDR_W  captured destIn; drives bank regC
- illegal  out  1  pulses with done when a divide op is issued in a build without divide support

## Operation
- FSM states: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values: ready=1, busy=0, done=0, writeFlag=0, illegal=0, result=0, destOut=0, counter=0.
- Accept condition: start=1 while in IDLE or DONE (ready=1). On accept, the unit latches op, operandA, operandB and destIn, loads counter=WIDTH and enters RUN.
- start while in RUN is ignored and is not queued.
- MUL/MULHU: unsigned shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator. MUL returns acc[WIDTH-1:0]; MULHU returns acc[2*WIDTH-1:WIDTH].
- DIVU/REMU: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits wide for the trial subtract.
- Divide by zero: the unit still runs the full WIDTH cycles. Quotient is all ones; remainder is operandA. No exception is raised.
- RUN decrements the counter each cycle. At counter==1 the FSM moves to DONE and the result register is loaded.
- DONE lasts exactly one cycle with done=writeFlag=1. It then goes to IDLE, or back to RUN if start is accepted in that same cycle.
- Reset asserted mid-operation returns the unit to IDLE immediately. No done pulse is produced and no write reaches the bank.
- All arithmetic is unsigned modulo 2^WIDTH. There are no signed ops.

## Timing
- Accept at rising edge t → busy=1 during cycles t+1 .. t+WIDTH.
- done, writeFlag, result and destOut are valid in cycle t+WIDTH+1. Latency is WIDTH+1 cycles, fixed for every op and every operand value.
- ready=0 exactly while busy=1.
- Back-to-back operation: a start in the DONE cycle gives a throughput of one op per WIDTH+1 cycles.
- result and destOut stay stable from DONE until the next accept.

## Configuration
- Macro: MULDIV_DIV_EN.
- Defined: DIVU/REMU behave as described above, and illegal stays 0.
- Undefined: the divider datapath is not compiled. A DIVU/REMU accept skips RUN and goes to DONE on the next edge (latency 1) with result=0 and illegal=1 for that cycle. writeFlag is still asserted, so the bank writes 0.

## Structure
- Shared package muldiv_pkg holds:
  - the op encoding as an enum (MUL, MULHU, DIVU, REMU)
  - the FSM state enum
  - the WIDTH and REG_ADDR_W default constants
- One sub-module, muldiv_divider, holds the restoring-divide step registers. It is instantiated only under MULDIV_DIV_EN.
- The multiplier iteration stays in the top module.

## Test plan
- Reset, then MUL with operandA=7, operandB=6, destIn=3 → done at cycle t+33, result=42, destOut=3, writeFlag=1 for exactly one cycle.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. The same operands with MUL → result=0x00000001.
- DIVU 100/7 → result=14; REMU 100/7 → result=2; DIVU 5/0 → result=0xFFFFFFFF; REMU 5/0 → result=5.
- start pulsed mid-RUN with different operands → ignored, and the first op's result is unchanged. A start in the DONE cycle is accepted, and the second done arrives WIDTH+1 cycles later.
- Reset asserted at cycle t+10 of a MUL → busy=0 and ready=1 immediately, and no done/writeFlag pulse follows.
- Build without MULDIV_DIV_EN, issue DIVU → done one cycle after accept, result=0, illegal=1.
